// File: rtl/keccak_pkg.sv
// Shared constants, FSM encoding and iota round-constant table for the masked
// Keccak-f[1600] round controller.
package keccak_pkg;

   localparam int unsigned NSHARE  = 4;
   localparam int unsigned W       = 1600;
   localparam int unsigned NROUND  = 24;
   localparam int unsigned ROUND_W = 5;
   localparam int unsigned RC_W    = 64;
   localparam int unsigned SW      = NSHARE * W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } keccak_st_e;

   localparam logic [RC_W-1:0] RC_TABLE [NROUND] = '{
      64'h0000_0000_0000_0001, 64'h0000_0000_0000_8082,
      64'h8000_0000_0000_808A, 64'h8000_0000_8000_8000,
      64'h0000_0000_0000_808B, 64'h0000_0000_8000_0001,
      64'h8000_0000_8000_8081, 64'h8000_0000_0000_8009,
      64'h0000_0000_0000_008A, 64'h0000_0000_0000_0088,
      64'h0000_0000_8000_8009, 64'h0000_0000_8000_000A,
      64'h0000_0000_8000_808B, 64'h8000_0000_0000_008B,
      64'h8000_0000_0000_8089, 64'h8000_0000_0000_8003,
      64'h8000_0000_0000_8002, 64'h8000_0000_0000_0080,
      64'h0000_0000_0000_800A, 64'h8000_0000_8000_000A,
      64'h8000_0000_8000_8081, 64'h8000_0000_0000_8080,
      64'h0000_0000_8000_0001, 64'h8000_0000_8000_8008
   };

   // Indices past the last round map to zero rather than aliasing a table entry.
   function automatic logic [RC_W-1:0] keccak_rc(input logic [ROUND_W-1:0] round);
      logic [RC_W-1:0] rc;
      rc = '0;
      for (int unsigned i = 0; i < NROUND; i++) begin
         if (round == ROUND_W'(i)) begin
            rc = RC_TABLE[i];
         end
      end
      return rc;
   endfunction

endpackage

// File: rtl/keccak_rc_rom.sv
// Combinational iota round-constant lookup indexed by the registered round counter.
module keccak_rc_rom
   import keccak_pkg::*;
(
   input  logic [ROUND_W-1:0] round_i,
   output logic [RC_W-1:0]    rc_c
);

   assign rc_c = keccak_rc(round_i);

endmodule

// File: rtl/keccak_round_ctrl.sv
// Round sequencer for the masked Keccak-f[1600] datapath: selects the next value of
// the share register (load / round output / hold) and runs the 24-round permutation.
module keccak_round_ctrl
   import keccak_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic [SW-1:0]      load_di,
   input  logic               start_i,
   input  logic [SW-1:0]      round_di,
   input  logic [SW-1:0]      state_qi,
   output logic [SW-1:0]      state_do,
   output logic [ROUND_W-1:0] round_o,
   output logic [RC_W-1:0]    rc_o,
   output logic               busy_o,
   output logic               done_o
);

   keccak_st_e         state_q, state_d;
   logic [ROUND_W-1:0] round_q, round_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [RC_W-1:0]    rc_c;

   keccak_rc_rom u_rc_rom (
      .round_i (round_q),
      .rc_c    (rc_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         round_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic; a load in the same cycle as start wins and start is dropped.
   always_comb begin
      state_d = state_q;
      round_d = round_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i && !load_i) begin
               state_d = ST_RUN;
               round_d = '0;
               busy_d  = 1'b1;
            end
         end
         ST_RUN: begin
            if (round_q == ROUND_W'(NROUND - 1)) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               round_d = round_q + ROUND_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Share-register input select: kept to a single 3:1 level on the wide path.
   always_comb begin
      state_do = state_qi;
      case (state_q)
         ST_IDLE: begin
            if (load_i) begin
               state_do = load_di;
            end
         end
         ST_RUN:  state_do = round_di;
         default: state_do = state_qi;
      endcase
   end

   assign rc_o    = (state_q == ST_RUN) ? rc_c : '0;
   assign round_o = round_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Self-checking bench: models the share register and a masked round function around
// the controller and checks sequencing, round constants and permutation results.
module tb_keccak_round_ctrl;
   import keccak_pkg::*;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                load_i = 1'b0;
   logic                start_i = 1'b0;
   logic [SW-1:0]       load_di = '0;
   logic [SW-1:0]       round_di;
   logic [SW-1:0]       state_qi;
   logic [SW-1:0]       state_do;
   logic [ROUND_W-1:0]  round_o;
   logic [RC_W-1:0]     rc_o;
   logic                busy_o;
   logic                done_o;
   logic [(NSHARE-1)*W-1:0] mask = '0;

   int checks = 0;
   int errors = 0;

   localparam logic [63:0] ZERO_LANE0 = 64'hF125_8F79_40E1_DDE7;

   always #5 clk = ~clk;

   keccak_round_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (load_i),
      .load_di  (load_di),
      .start_i  (start_i),
      .round_di (round_di),
      .state_qi (state_qi),
      .state_do (state_do),
      .round_o  (round_o),
      .rc_o     (rc_o),
      .busy_o   (busy_o),
      .done_o   (done_o)
   );

   // Share register model (no reset, like the real one)
   always @(posedge clk) state_qi <= state_do;

   // ---------------- reference model ----------------
   function automatic logic [63:0] rot64(input logic [63:0] v, input int n);
      if (n == 0) return v;
      return (v << n) | (v >> (64 - n));
   endfunction

   function automatic logic rc_bit(input int t);
      logic [8:0] r;
      r = 9'h001;
      for (int i = 0; i < (t % 255); i++) begin
         r = r << 1;
         if (r[8]) r = r ^ 9'h171;
      end
      return r[0];
   endfunction

   function automatic logic [63:0] model_rc(input int ir);
      logic [63:0] rc;
      rc = '0;
      for (int j = 0; j < 7; j++) rc[(1 << j) - 1] = rc_bit(j + 7 * ir);
      return rc;
   endfunction

   function automatic logic [W-1:0] keccak_round(input logic [W-1:0] s, input logic [63:0] rc);
      logic [63:0] a [25];
      logic [63:0] b [25];
      logic [63:0] c [5];
      logic [63:0] d [5];
      int off [25];
      int x, y, nx;
      logic [W-1:0] r;
      for (int i = 0; i < 25; i++) a[i] = s[64*i +: 64];
      off[0] = 0;
      x = 1; y = 0;
      for (int t = 0; t < 24; t++) begin
         off[x + 5*y] = ((t + 1) * (t + 2) / 2) % 64;
         nx = y;
         y  = (2*x + 3*y) % 5;
         x  = nx;
      end
      for (int i = 0; i < 5; i++) c[i] = a[i] ^ a[i+5] ^ a[i+10] ^ a[i+15] ^ a[i+20];
      for (int i = 0; i < 5; i++) d[i] = c[(i+4)%5] ^ rot64(c[(i+1)%5], 1);
      for (int i = 0; i < 25; i++) a[i] = a[i] ^ d[i%5];
      for (int xi = 0; xi < 5; xi++)
         for (int yi = 0; yi < 5; yi++)
            b[yi + 5*((2*xi + 3*yi) % 5)] = rot64(a[xi + 5*yi], off[xi + 5*yi]);
      for (int xi = 0; xi < 5; xi++)
         for (int yi = 0; yi < 5; yi++)
            a[xi + 5*yi] = b[xi + 5*yi] ^ (~b[(xi+1)%5 + 5*yi] & b[(xi+2)%5 + 5*yi]);
      a[0] = a[0] ^ rc;
      for (int i = 0; i < 25; i++) r[64*i +: 64] = a[i];
      return r;
   endfunction

   function automatic logic [W-1:0] keccak_f(input logic [W-1:0] s);
      logic [W-1:0] v;
      v = s;
      for (int ir = 0; ir < 24; ir++) v = keccak_round(v, model_rc(ir));
      return v;
   endfunction

   function automatic logic [W-1:0] combine(input logic [SW-1:0] s);
      logic [W-1:0] c;
      c = '0;
      for (int i = 0; i < int'(NSHARE); i++) c = c ^ s[i*W +: W];
      return c;
   endfunction

   // Masked round stand-in: unmask, apply round with DUT's rc_o, remask with fresh shares
   function automatic logic [SW-1:0] masked_round(input logic [SW-1:0] sq,
                                                  input logic [63:0] rc,
                                                  input logic [(NSHARE-1)*W-1:0] m);
      logic [W-1:0] x;
      x = keccak_round(combine(sq), rc);
      for (int i = 0; i < int'(NSHARE) - 1; i++) x = x ^ m[i*W +: W];
      return {m, x};
   endfunction

   always_comb round_di = masked_round(state_qi, rc_o, mask);

   function automatic logic [W-1:0] rand_w();
      logic [W-1:0] v;
      for (int i = 0; i < int'(W) / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [SW-1:0] make_shares(input logic [W-1:0] plain);
      logic [SW-1:0] sh;
      logic [W-1:0]  acc;
      acc = plain;
      for (int i = 1; i < int'(NSHARE); i++) begin
         sh[i*W +: W] = rand_w();
         acc = acc ^ sh[i*W +: W];
      end
      sh[W-1:0] = acc;
      return sh;
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_load(input logic [W-1:0] plain);
      for (int i = 0; i < int'(NSHARE) - 1; i++) mask[i*W +: W] = rand_w();
      load_i  = 1'b1;
      load_di = make_shares(plain);
      tick();
      load_i  = 1'b0;
   endtask

   task automatic start_perm();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_done(inout int n);
      while (done_o !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      tick();
      tick();
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
      checks++; if (round_o !== 5'd0) begin errors++; $display("FAIL reset_round: got %0d expected 0", round_o); end
      checks++; if (rc_o !== 64'd0) begin errors++; $display("FAIL reset_rc: got %h expected 0", rc_o); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_load_hold();
      logic [SW-1:0] a;
      a = make_shares(rand_w());
      load_i = 1'b1;
      load_di = a;
      #1;
      checks++; if (state_do !== a) begin errors++; $display("FAIL load_mux: got %h expected %h", state_do[63:0], a[63:0]); end
      tick();
      load_i = 1'b0;
      load_di = make_shares(rand_w());
      #1;
      checks++; if (state_qi !== a) begin errors++; $display("FAIL load_capture: got %h expected %h", state_qi[63:0], a[63:0]); end
      checks++; if (state_do !== a) begin errors++; $display("FAIL hold_mux: got %h expected %h", state_do[63:0], a[63:0]); end
      tick();
      checks++; if (state_qi !== a) begin errors++; $display("FAIL hold_capture: got %h expected %h", state_qi[63:0], a[63:0]); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL load_busy: got %b expected 0", busy_o); end
   endtask

   task automatic test_full_perm();
      int n;
      logic [63:0]   lane0;
      logic [SW-1:0] final_q;
      drive_load('0);
      start_perm();
      n = 1;
      while (done_o !== 1'b1 && n < 40) begin
         checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL run_busy: cycle %0d got %b expected 1", n, busy_o); end
         checks++; if (round_o !== 5'(n - 1)) begin errors++; $display("FAIL run_round: cycle %0d got %0d expected %0d", n, round_o, n - 1); end
         checks++; if (rc_o !== model_rc(n - 1)) begin errors++; $display("FAIL run_rc: round %0d got %h expected %h", n - 1, rc_o, model_rc(n - 1)); end
         if (n == 1) begin
            checks++; if (rc_o !== 64'h0000_0000_0000_0001) begin errors++; $display("FAIL rc0: got %h expected 0000000000000001", rc_o); end
         end
         if (n == 2) begin
            checks++; if (rc_o !== 64'h0000_0000_0000_8082) begin errors++; $display("FAIL rc1: got %h expected 0000000000008082", rc_o); end
         end
         if (n == 24) begin
            checks++; if (rc_o !== 64'h8000_0000_8000_8008) begin errors++; $display("FAIL rc23: got %h expected 8000000080008008", rc_o); end
         end
         tick();
         n++;
      end
      checks++; if (n != 25) begin errors++; $display("FAIL perm_latency: got %0d expected 25", n); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL done_busy: got %b expected 0", busy_o); end
      checks++; if (rc_o !== 64'd0) begin errors++; $display("FAIL done_rc: got %h expected 0", rc_o); end
      lane0 = combine(state_qi)[63:0];
      checks++; if (lane0 !== ZERO_LANE0) begin errors++; $display("FAIL zero_lane0: got %h expected %h", lane0, ZERO_LANE0); end
      final_q = state_qi;
      load_i = 1'b1;
      load_di = make_shares(rand_w());
      #1;
      checks++; if (state_do !== final_q) begin errors++; $display("FAIL done_load_ignored: got %h expected %h", state_do[63:0], final_q[63:0]); end
      tick();
      load_i = 1'b0;
      checks++; if (state_qi !== final_q) begin errors++; $display("FAIL done_hold: got %h expected %h", state_qi[63:0], final_q[63:0]); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b expected 0", done_o); end
   endtask

   task automatic test_random_perm();
      int n;
      logic [W-1:0] p, exp_s, got_s;
      for (int k = 0; k < 2; k++) begin
         p = rand_w();
         exp_s = keccak_f(p);
         drive_load(p);
         start_perm();
         n = 1;
         wait_done(n);
         checks++; if (n != 25) begin errors++; $display("FAIL rand_latency: got %0d expected 25", n); end
         got_s = combine(state_qi);
         checks++; if (got_s !== exp_s) begin errors++; $display("FAIL rand_perm: got %h expected %h", got_s[127:0], exp_s[127:0]); end
         tick();
      end
   endtask

   task automatic test_ignored();
      int n;
      logic [63:0] lane0;
      drive_load('0);
      start_perm();
      n = 1;
      while (round_o !== 5'd5 && n < 10) begin
         tick();
         n++;
      end
      start_i = 1'b1;
      load_i  = 1'b1;
      load_di = make_shares(rand_w());
      #1;
      checks++; if (state_do !== round_di) begin errors++; $display("FAIL ign_mux: got %h expected %h", state_do[63:0], round_di[63:0]); end
      tick();
      n++;
      start_i = 1'b0;
      load_i  = 1'b0;
      checks++; if (round_o !== 5'd6) begin errors++; $display("FAIL ign_round: got %0d expected 6", round_o); end
      wait_done(n);
      checks++; if (n != 25) begin errors++; $display("FAIL ign_latency: got %0d expected 25", n); end
      lane0 = combine(state_qi)[63:0];
      checks++; if (lane0 !== ZERO_LANE0) begin errors++; $display("FAIL ign_lane0: got %h expected %h", lane0, ZERO_LANE0); end
      tick();
   endtask

   task automatic test_simultaneous();
      int n;
      logic [SW-1:0] b;
      b = make_shares(rand_w());
      load_i  = 1'b1;
      start_i = 1'b1;
      load_di = b;
      #1;
      checks++; if (state_do !== b) begin errors++; $display("FAIL sim_mux: got %h expected %h", state_do[63:0], b[63:0]); end
      tick();
      load_i  = 1'b0;
      start_i = 1'b0;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL sim_busy: got %b expected 0", busy_o); end
      checks++; if (state_qi !== b) begin errors++; $display("FAIL sim_load: got %h expected %h", state_qi[63:0], b[63:0]); end
      start_perm();
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL sim_start_busy: got %b expected 1", busy_o); end
      checks++; if (round_o !== 5'd0) begin errors++; $display("FAIL sim_start_round: got %0d expected 0", round_o); end
      n = 1;
      wait_done(n);
      checks++; if (n != 25) begin errors++; $display("FAIL sim_latency: got %0d expected 25", n); end
      tick();
   endtask

   task automatic test_reset_mid_run();
      int n;
      int seen;
      drive_load('0);
      start_perm();
      n = 1;
      while (round_o !== 5'd10 && n < 20) begin
         tick();
         n++;
      end
      checks++; if (round_o !== 5'd10) begin errors++; $display("FAIL mid_reach10: got %0d expected 10", round_o); end
      rst_n = 1'b0;
      #1;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy_o); end
      checks++; if (round_o !== 5'd0) begin errors++; $display("FAIL mid_rst_round: got %0d expected 0", round_o); end
      checks++; if (rc_o !== 64'd0) begin errors++; $display("FAIL mid_rst_rc: got %h expected 0", rc_o); end
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         if (done_o === 1'b1 || busy_o === 1'b1) seen++;
         tick();
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL mid_rst_no_done: got %0d active cycles expected 0", seen); end
   endtask

   initial begin
      test_reset();
      test_load_hold();
      test_full_perm();
      test_random_perm();
      test_ignored();
      test_simultaneous();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
